// File: rtl/clk_out_pkg.sv
// Shared state encoding and default divide ratio for the clock-output path.
package clk_out_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STOP_PEND = 2'd2,
      ST_STEP      = 2'd3
   } clk_state_e;

   localparam logic [15:0] DEFAULT_DIV = 16'd50000;

endpackage

// File: rtl/clk_period_counter.sv
// Period counter: counts 0..div_eff-1 while enabled, parks at 0 otherwise.
module clk_period_counter #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_eff,
   output logic [DIV_W-1:0] cnt,
   output logic             last
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   always_comb begin
      last = (cnt_q == div_eff - DIV_W'(1));
      cnt_d = '0;
      if (en && !last) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/clk_out_gen.sv
// CPU clock-enable tick and forwarded divided clock with run/halt/step control.
module clk_out_gen
   import clk_out_pkg::*;
#(
   parameter int unsigned       DIV_W       = 16,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(clk_out_pkg::DEFAULT_DIV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   input  logic             run,
   input  logic             step,
   output logic             ce,
   output logic             ext_clk_out,
   output logic             running,
   output logic             step_ack
);

   clk_state_e       state_q, state_d;
   logic [DIV_W-1:0] div_shadow_q, div_shadow_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic             ext_clk_q, ext_clk_d;
   logic             step_ack_q, step_ack_d;

   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] cnt;
   logic             last;

   assign div_eff = (div_act_q == '0) ? DIV_W'(1) : div_act_q;
   assign running = (state_q != ST_IDLE);
   assign ce      = running && last;

   clk_period_counter #(
      .DIV_W(DIV_W)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (running),
      .div_eff (div_eff),
      .cnt     (cnt),
      .last    (last)
   );

   always_comb begin
      div_shadow_d = div_load ? div_val : div_shadow_q;
      // Forward a coincident load so it governs the very next period.
      div_act_d    = (ce || !running) ? div_shadow_d : div_act_q;
      // div_eff>>1 is 0 for a ratio of 1, which pins the pin low.
      ext_clk_d    = running && (cnt < (div_eff >> 1));
      step_ack_d   = (state_q == ST_STEP) && ce;

      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_RUN;
            end else if (step) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (!run) begin
               state_d = ce ? ST_IDLE : ST_STOP_PEND;
            end
         end
         ST_STOP_PEND: begin
            if (run) begin
               state_d = ST_RUN;
            end else if (ce) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (ce) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         div_shadow_q <= DEFAULT_DIV;
         div_act_q    <= DEFAULT_DIV;
         ext_clk_q    <= 1'b0;
         step_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_shadow_q <= div_shadow_d;
         div_act_q    <= div_act_d;
         ext_clk_q    <= ext_clk_d;
         step_ack_q   <= step_ack_d;
      end
   end

   assign ext_clk_out = ext_clk_q;
   assign step_ack    = step_ack_q;

endmodule
